snake_dir_ctrl: RTL and testbench

- Direction controller directly downstream of the button scanner. Consumes the scanner's single-cycle press pulses (left/right/up/down).
- Filters illegal turns (no-op, 180° reversal) and buffers legal turns in a small FIFO. Applies one turn per game move tick.
- Drives the registered snake heading to the snake-body/movement logic.

---
 rtl/snake_dir_ctrl_pkg.sv | 9 +
 rtl/snake_dir_ctrl_dir_fifo.sv | 48 ++++
 rtl/snake_dir_ctrl.sv | 83 ++++++++
 tb/tb_snake_dir_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/snake_dir_ctrl_pkg.sv
// snake_pkg: heading and state types shared by snake_dir_ctrl and its turn FIFO.
package snake_pkg;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT, ST_PAUSE} state_t;
    // UP/DOWN and LEFT/RIGHT differ only in the low bit of the encoding
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction
endpackage

// File: rtl/snake_dir_ctrl_dir_fifo.sv
// dir_fifo: DEPTH-entry heading FIFO with flush, head/tail peek and simultaneous push/pop.
module dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  dir_t                     din,
    output dir_t                     head,
    output dir_t                     tail,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    dir_t mem [DEPTH];
    logic [PW-1:0] rp, wp;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (PW+1)'(DEPTH);
    assign do_pop = pop && !empty;
    // a pop in the same cycle frees the slot a full-queue push needs
    assign do_push = push && (!full || do_pop);
    assign head = mem[rp];
    assign tail = mem[wp - 1'b1];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rp <= '0;
            wp <= '0;
            count <= '0;
        end else if (flush) begin
            rp <= '0;
            wp <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wp] <= din;
    end
endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: filters button turns, queues legal ones and applies one per move tick.
// Defining SNAKE_DIR_PAUSE_EN adds a PAUSE state toggled by pause_press.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int         QDEPTH   = 2,
    parameter logic [1:0] INIT_DIR = 2'd3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      left_press,
    input  logic                      right_press,
    input  logic                      up_press,
    input  logic                      down_press,
    input  logic                      pause_press,
    input  logic                      move_tick,
    input  logic                      game_over,
    input  logic                      restart,
    output logic [1:0]                dir,
    output logic                      moving,
    output logic                      dir_changed,
    output logic                      overflow,
    output logic [$clog2(QDEPTH):0]   q_count
);
    state_t state, nxt;
    dir_t cand, head, tail, ref_dir;
    logic any_press, legal, active, go_halt, pop, push_ok, full, empty;
    assign any_press = up_press | down_press | left_press | right_press;
    assign cand = up_press ? DIR_UP : down_press ? DIR_DOWN : left_press ? DIR_LEFT : DIR_RIGHT;
    // legality is judged against the last queued turn, not the current heading
    assign ref_dir = empty ? dir_t'(dir) : tail;
    assign legal = any_press && cand != ref_dir && cand != opposite(ref_dir);
    assign go_halt = !restart && game_over && (state == ST_RUN || state == ST_PAUSE);
    assign active = !restart && (state == ST_IDLE || (state == ST_RUN && !game_over));
    assign pop = active && state == ST_RUN && move_tick && !empty;
    assign push_ok = active && legal;

    dir_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop),
        .flush (restart || go_halt),
        .din   (cand),
        .head  (head),
        .tail  (tail),
        .count (q_count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        nxt = state;
        if (restart) nxt = ST_IDLE;
        else if (go_halt) nxt = ST_HALT;
        else if (state == ST_IDLE && push_ok) nxt = ST_RUN;
`ifdef SNAKE_DIR_PAUSE_EN
        else if (pause_press && state == ST_RUN) nxt = ST_PAUSE;
        else if (pause_press && state == ST_PAUSE) nxt = ST_RUN;
`endif
    end

`ifndef SNAKE_DIR_PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause_press;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            dir <= INIT_DIR;
            moving <= 1'b0;
            dir_changed <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= nxt;
            dir <= restart ? INIT_DIR : pop ? head : dir;
            moving <= nxt == ST_RUN;
            dir_changed <= pop;
            overflow <= push_ok && full && !pop;
        end
    end
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: directed vector table plus randomized run against a queue-based model.
module tb_snake_dir_ctrl;
    localparam int QD = 2;
    localparam bit [6:0] U = 7'b1000000, D = 7'b0100000, L = 7'b0010000, R = 7'b0001000;
    localparam bit [6:0] TK = 7'b0000100, GO = 7'b0000010, RS = 7'b0000001, NO = 7'b0000000;
    localparam int IDLE = 0, RUN = 1, HALT = 2, PAUSE = 3;

    logic clk = 0, rst = 0;
    logic left_press = 0, right_press = 0, up_press = 0, down_press = 0;
    logic pause_press = 0, move_tick = 0, game_over = 0, restart = 0;
    logic [1:0] dir;
    logic moving, dir_changed, overflow;
    logic [1:0] q_count;

    always #5 clk = ~clk;

    snake_dir_ctrl #(.QDEPTH(QD), .INIT_DIR(2'd3)) dut (
        .clk(clk), .rst(rst),
        .left_press(left_press), .right_press(right_press),
        .up_press(up_press), .down_press(down_press),
        .pause_press(pause_press), .move_tick(move_tick),
        .game_over(game_over), .restart(restart),
        .dir(dir), .moving(moving), .dir_changed(dir_changed),
        .overflow(overflow), .q_count(q_count)
    );

    typedef struct {
        bit [6:0] in;
        int d, qc, mv, ch, ov;
    } vec_t;
    vec_t tbl[$];

    int compared = 0, mismatched = 0;
    int ms, md, mch, mov;
    int mq[$];
    int opp_t[4] = '{1, 0, 3, 2};

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect5(input string tag, input int d, input int qc, input int mv, input int ch, input int ov);
        chk({tag, ".dir"}, int'(dir), d);
        chk({tag, ".q_count"}, int'(q_count), qc);
        chk({tag, ".moving"}, int'(moving), mv);
        chk({tag, ".dir_changed"}, int'(dir_changed), ch);
        chk({tag, ".overflow"}, int'(overflow), ov);
    endtask

    task automatic apply(input bit [6:0] in, input bit p);
        @(negedge clk);
        {up_press, down_press, left_press, right_press, move_tick, game_over, restart} = in;
        pause_press = p;
        @(posedge clk);
        #1;
    endtask

    task automatic v(input bit [6:0] in, input int d, input int qc, input int mv, input int ch, input int ov);
        tbl.push_back(vec_t'{in, d, qc, mv, ch, ov});
    endtask

    // Behavioural reference: one game cycle computed from the controller's rules on a plain queue
    task automatic model_step(input bit [6:0] in, input bit p);
        int cand, refd, s0;
        bit legal;
        s0 = ms;
        mch = 0;
        mov = 0;
        if (in[0]) begin
            ms = IDLE; mq.delete(); md = 3;
        end else if (in[1] && (ms == RUN || ms == PAUSE)) begin
            ms = HALT; mq.delete();
        end else begin
            if (ms == IDLE || ms == RUN) begin
                cand = in[6] ? 0 : in[5] ? 1 : in[4] ? 2 : in[3] ? 3 : -1;
                refd = mq.size() > 0 ? mq[$] : md;
                legal = cand >= 0 && cand != refd && cand != opp_t[refd];
                if (ms == RUN && in[2] && mq.size() > 0) begin
                    md = mq.pop_front();
                    mch = 1;
                end
                if (legal) begin
                    if (mq.size() < QD) mq.push_back(cand);
                    else mov = 1;
                    if (ms == IDLE) ms = RUN;
                end
            end
`ifdef SNAKE_DIR_PAUSE_EN
            if (p && s0 == RUN) ms = PAUSE;
            else if (p && s0 == PAUSE) ms = RUN;
`endif
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect5("reset", 3, 0, 0, 0, 0);
        @(negedge clk) rst = 1;

        v(NO, 3, 0, 0, 0, 0);  v(U, 3, 1, 1, 0, 0);   v(NO, 3, 1, 1, 0, 0); v(NO, 3, 1, 1, 0, 0);
        v(TK, 0, 0, 1, 1, 0);  v(NO, 0, 0, 1, 0, 0);  v(RS, 3, 0, 0, 0, 0); v(L, 3, 0, 0, 0, 0);
        v(R, 3, 0, 0, 0, 0);   v(U, 3, 1, 1, 0, 0);   v(R, 3, 2, 1, 0, 0);  v(TK, 0, 1, 1, 1, 0);
        v(TK, 3, 0, 1, 1, 0);  v(L, 3, 0, 1, 0, 0);   v(R, 3, 0, 1, 0, 0);  v(U, 3, 1, 1, 0, 0);
        v(L, 3, 2, 1, 0, 0);   v(D, 3, 2, 1, 0, 1);   v(TK, 0, 1, 1, 1, 0); v(TK, 2, 0, 1, 1, 0);
        v(U | L, 2, 1, 1, 0, 0); v(TK, 0, 0, 1, 1, 0); v(L, 0, 1, 1, 0, 0); v(D, 0, 2, 1, 0, 0);
        v(TK | R, 2, 2, 1, 1, 0); v(NO, 2, 2, 1, 0, 0); v(GO, 2, 0, 0, 0, 0); v(TK, 2, 0, 0, 0, 0);
        v(U, 2, 0, 0, 0, 0);   v(RS, 3, 0, 0, 0, 0);  v(TK, 3, 0, 0, 0, 0); v(U, 3, 1, 1, 0, 0);
        v(RS | L, 3, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            apply(tbl[i].in, 0);
            expect5($sformatf("vec%0d", i), tbl[i].d, tbl[i].qc, tbl[i].mv, tbl[i].ch, tbl[i].ov);
        end

`ifdef SNAKE_DIR_PAUSE_EN
        apply(U, 0);  expect5("pz_press", 3, 1, 1, 0, 0);
        apply(NO, 1); expect5("pz_enter", 3, 1, 0, 0, 0);
        apply(TK, 0); expect5("pz_tick", 3, 1, 0, 0, 0);
        apply(L, 0);  expect5("pz_press_ign", 3, 1, 0, 0, 0);
        apply(NO, 1); expect5("pz_exit", 3, 1, 1, 0, 0);
        apply(TK, 0); expect5("pz_apply", 0, 0, 1, 1, 0);
`else
        apply(U, 0);  expect5("nopz_press", 3, 1, 1, 0, 0);
        apply(NO, 1); expect5("nopz_pause", 3, 1, 1, 0, 0);
        apply(TK, 0); expect5("nopz_tick", 0, 0, 1, 1, 0);
`endif

        apply(L, 0);
        expect5("pre_arst", 0, 1, 1, 0, 0);
        @(negedge clk);
        #2 rst = 0;
        #1 expect5("async_rst", 3, 0, 0, 0, 0);
        @(negedge clk) rst = 1;

        ms = IDLE; md = 3; mq.delete();
        for (int i = 0; i < 3000; i++) begin
            bit [6:0] in;
            bit p;
            in[6] = $urandom_range(0, 99) < 20;
            in[5] = $urandom_range(0, 99) < 20;
            in[4] = $urandom_range(0, 99) < 20;
            in[3] = $urandom_range(0, 99) < 20;
            in[2] = $urandom_range(0, 99) < 25;
            in[1] = $urandom_range(0, 99) < 2;
            in[0] = $urandom_range(0, 99) < 2;
            p = $urandom_range(0, 99) < 6;
            apply(in, p);
            model_step(in, p);
            expect5($sformatf("rnd%0d", i), md, mq.size(), int'(ms == RUN), mch, mov);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
